// File: rtl/enc_clk_ctrl_if.sv
// Front-panel bundle: raw buttons and encoder phases in; divider select, divided clock,
// tick and LED thermometer out.
interface enc_clk_ctrl_if #(parameter int SEL_W = 4);
    logic             btn_set;
    logic             btn_clr;
    logic             btn_up;
    logic             btn_down;
    logic             enc_a;
    logic             enc_b;
    logic [SEL_W-1:0] sel;
    logic             clk_div;
    logic             clk_tick;
    logic [7:0]       led;

    modport slave  (input  btn_set, btn_clr, btn_up, btn_down, enc_a, enc_b,
                    output sel, clk_div, clk_tick, led);
    modport master (output btn_set, btn_clr, btn_up, btn_down, enc_a, enc_b,
                    input  sel, clk_div, clk_tick, led);
endinterface

// File: rtl/enc_clk_ctrl.sv
// Front-panel clock controller: debounced buttons and quadrature encoder steer a
// divider select that sets the period of a glitch-free divided clock.
module enc_clk_ctrl #(
    parameter int SEL_W     = 4,
    parameter int DB_CYCLES = 500000,
    parameter int DB_CNT_W  = 20,
    parameter int WRAP      = 0,
    parameter int SEL_INIT  = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    enc_clk_ctrl_if.slave bus
);
    localparam int                  CNT_W   = 2 ** SEL_W;
    localparam int                  SUM_W   = SEL_W + 2;
    localparam logic [SEL_W-1:0]    SEL_MAX = '1;
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

    // Bit order: 0 clr, 1 set, 2 up, 3 down, 5:4 encoder {A,B}
    logic [5:0] raw;
    logic [5:0] sync1_q, sync2_q;

    logic [3:0][DB_CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [3:0]               db_state_q, db_state_d;
    logic [3:0]               press_q, press_d;

    logic [1:0] enc_prev_q, enc_pos_cur, enc_pos_prev, enc_diff;
    logic [2:0] acc_q, acc_d;
    logic [3:0] acc_sum;
    logic       enc_inc_q, enc_inc_d, enc_dec_q, enc_dec_d;

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SUM_W-1:0] sel_sum;
    logic [CNT_W-1:0] div_cnt_q, div_term;
    logic             div_q, tick_q;
    logic [7:0]       led;

    assign raw = {bus.enc_a, bus.enc_b, bus.btn_down, bus.btn_up, bus.btn_set, bus.btn_clr};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i]   = '0;
            db_state_d[i] = db_state_q[i];
            press_d[i]    = 1'b0;
            if (sync2_q[i] != db_state_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_state_d[i] = sync2_q[i];
                    press_d[i]    = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Gray position {A, A^B} turns a quadrature transition into a modulo-4 step;
    // a difference of 2 means both phases moved at once and is treated as noise.
    always_comb begin
        enc_pos_cur  = {sync2_q[5], sync2_q[5] ^ sync2_q[4]};
        enc_pos_prev = {enc_prev_q[1], enc_prev_q[1] ^ enc_prev_q[0]};
        enc_diff     = enc_pos_cur - enc_pos_prev;
        acc_sum      = {acc_q[2], acc_q};
        acc_d        = acc_q;
        enc_inc_d    = 1'b0;
        enc_dec_d    = 1'b0;
        if (enc_diff == 2'd1)      acc_sum = acc_sum + 4'd1;
        else if (enc_diff == 2'd3) acc_sum = acc_sum - 4'd1;
        if (enc_diff == 2'd2) begin
            acc_d = '0;
        end else if (acc_sum == 4'h4) begin
            acc_d     = '0;
            enc_inc_d = 1'b1;
        end else if (acc_sum == 4'hC) begin
            acc_d     = '0;
            enc_dec_d = 1'b1;
        end else begin
            acc_d = acc_sum[2:0];
        end
    end

    always_comb begin
        sel_sum = {2'b00, sel_q} + SUM_W'(press_q[2]) + SUM_W'(enc_inc_q)
                - SUM_W'(press_q[3]) - SUM_W'(enc_dec_q);
        sel_d = sel_q;
        if (press_q[0])               sel_d = '0;
        else if (press_q[1])          sel_d = SEL_MAX;
        else if (WRAP != 0)           sel_d = sel_sum[SEL_W-1:0];
        else if (sel_sum[SUM_W-1])    sel_d = '0;
        else if (sel_sum[SEL_W])      sel_d = SEL_MAX;
        else                          sel_d = sel_sum[SEL_W-1:0];
    end

    assign div_term = (CNT_W'(1) << sel_q) - CNT_W'(1);

    always_comb begin
        for (int i = 0; i < 8; i++) led[i] = (int'(sel_q) > i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_cnt_q   <= '0;
            db_state_q <= '0;
            press_q    <= '0;
            enc_prev_q <= '0;
            acc_q      <= '0;
            enc_inc_q  <= 1'b0;
            enc_dec_q  <= 1'b0;
            sel_q      <= SEL_W'(SEL_INIT);
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            db_state_q <= db_state_d;
            press_q    <= press_d;
            enc_prev_q <= sync2_q[5:4];
            acc_q      <= acc_d;
            enc_inc_q  <= enc_inc_d;
            enc_dec_q  <= enc_dec_d;
            sel_q      <= sel_d;
        end
    end

    // A select change restarts the half-period without touching the output level,
    // so no phase of the divided clock is ever cut short.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else if (sel_d != sel_q) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else if (div_cnt_q == div_term) begin
            div_cnt_q <= '0;
            div_q     <= ~div_q;
            tick_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
            tick_q    <= 1'b0;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.clk_div  = div_q;
    assign bus.clk_tick = tick_q;
    assign bus.led      = led;
endmodule

// File: tb/tb_enc_clk_ctrl.sv
// Scoreboard bench for enc_clk_ctrl: two instances (saturate and wrap) share stimulus;
// expected SEL updates are queued by the stimulus and consumed by a monitor.
module tb_enc_clk_ctrl;
    localparam int SEL_W = 4;

    logic clk = 1'b0;
    logic rstN;
    int   testsRun = 0;
    int   testsFailed = 0;

    logic [SEL_W-1:0] expQ[$];
    logic [SEL_W-1:0] lastSel;
    logic             monEn = 1'b0;
    logic             prevDiv;

    enc_clk_ctrl_if #(.SEL_W(SEL_W)) bus0 ();
    enc_clk_ctrl_if #(.SEL_W(SEL_W)) bus1 ();

    assign bus1.btn_set  = bus0.btn_set;
    assign bus1.btn_clr  = bus0.btn_clr;
    assign bus1.btn_up   = bus0.btn_up;
    assign bus1.btn_down = bus0.btn_down;
    assign bus1.enc_a    = bus0.enc_a;
    assign bus1.enc_b    = bus0.enc_b;

    enc_clk_ctrl #(.SEL_W(SEL_W), .DB_CYCLES(4), .DB_CNT_W(3), .WRAP(0), .SEL_INIT(3)) dut0 (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus0.slave)
    );

    enc_clk_ctrl #(.SEL_W(SEL_W), .DB_CYCLES(4), .DB_CNT_W(3), .WRAP(1), .SEL_INIT(3)) dut1 (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) prevDiv <= bus0.clk_div;

    function automatic void checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endfunction

    // Monitor: every observed SEL change must match the head of the expectation queue
    initial begin
        forever begin
            @(negedge clk);
            if (monEn && bus0.sel !== lastSel) begin
                if (expQ.size() == 0) checkOutput("unexpected sel change", int'(bus0.sel), int'(lastSel));
                else                  checkOutput("sel update", int'(bus0.sel), int'(expQ.pop_front()));
                lastSel = bus0.sel;
            end
        end
    end

    // Buttons are {down, up, set, clr}
    task automatic applyStimulus(input logic [3:0] btns, input int hold);
        @(negedge clk);
        {bus0.btn_down, bus0.btn_up, bus0.btn_set, bus0.btn_clr} = btns;
        repeat (hold) @(negedge clk);
        {bus0.btn_down, bus0.btn_up, bus0.btn_set, bus0.btn_clr} = 4'b0000;
        repeat (12) @(negedge clk);
    endtask

    task automatic encStep(input logic a, input logic b);
        @(negedge clk);
        bus0.enc_a = a;
        bus0.enc_b = b;
        repeat (3) @(negedge clk);
    endtask

    task automatic encDetentFwd();
        encStep(1'b0, 1'b1);
        encStep(1'b1, 1'b1);
        encStep(1'b1, 1'b0);
        encStep(1'b0, 1'b0);
    endtask

    task automatic encDetentRev();
        encStep(1'b1, 1'b0);
        encStep(1'b1, 1'b1);
        encStep(1'b0, 1'b1);
        encStep(1'b0, 1'b0);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, expQ.size(), 0);
        expQ.delete();
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int  n;
        logic d0;
        logic found;

        rstN = 1'b0;
        {bus0.btn_down, bus0.btn_up, bus0.btn_set, bus0.btn_clr} = 4'b0000;
        bus0.enc_a = 1'b0;
        bus0.enc_b = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset sel", int'(bus0.sel), 3);
        checkOutput("reset led", int'(bus0.led), 8'h07);
        checkOutput("reset clk_div", int'(bus0.clk_div), 0);
        checkOutput("reset clk_tick", int'(bus0.clk_tick), 0);
        rstN = 1'b1;
        lastSel = 4'd3;
        monEn = 1'b1;

        // Half-period at SEL=3 is 8 cycles from reset release
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            found = bus0.clk_tick;
        end
        checkOutput("first toggle latency sel=3", n, 8);
        d0 = bus0.clk_div;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus0.clk_tick && n < 40);
        checkOutput("toggle interval sel=3", n, 8);
        checkOutput("clk_div toggled", int'(bus0.clk_div), int'(!d0));

        // Too-short press is rejected, a long hold steps exactly once
        applyStimulus(4'b0100, 3);
        expQ.push_back(4'd4);
        applyStimulus(4'b0100, 10);
        waitDrain("up press");
        checkOutput("led sel=4", int'(bus0.led), 8'h0F);

        expQ.push_back(4'd5);
        expQ.push_back(4'd6);
        encDetentFwd();
        encDetentFwd();
        waitDrain("encoder forward x2");
        expQ.push_back(4'd5);
        encDetentRev();
        waitDrain("encoder reverse");

        // Double-bit jump clears the partial count; two more steps must not complete a detent
        encStep(1'b0, 1'b1);
        encStep(1'b1, 1'b1);
        encStep(1'b0, 1'b0);
        encStep(1'b0, 1'b1);
        encStep(1'b1, 1'b1);
        encStep(1'b0, 1'b1);
        encStep(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("illegal step sel", int'(bus0.sel), 5);

        expQ.push_back(4'd15);
        applyStimulus(4'b0010, 10);
        waitDrain("set press");
        checkOutput("led sel=15", int'(bus0.led), 8'hFF);
        applyStimulus(4'b0100, 10);
        checkOutput("saturate at max", int'(bus0.sel), 15);
        checkOutput("wrap sel", int'(bus1.sel), 0);
        checkOutput("wrap led", int'(bus1.led), 0);
        @(negedge clk);
        d0 = bus1.clk_div;
        @(negedge clk);
        checkOutput("wrap period2 toggle a", int'(bus1.clk_div), int'(!d0));
        checkOutput("wrap period2 tick", int'(bus1.clk_tick), 1);
        @(negedge clk);
        checkOutput("wrap period2 toggle b", int'(bus1.clk_div), int'(d0));

        expQ.push_back(4'd0);
        applyStimulus(4'b0011, 10);
        waitDrain("clr and set together");
        expQ.push_back(4'd1);
        applyStimulus(4'b0100, 10);
        expQ.push_back(4'd2);
        applyStimulus(4'b0100, 10);
        waitDrain("two up presses");

        // UP pulse lands in the same cycle as the encoder's decrement pulse
        encStep(1'b1, 1'b0);
        encStep(1'b1, 1'b1);
        encStep(1'b0, 1'b1);
        @(negedge clk);
        bus0.btn_up = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus0.enc_a = 1'b0;
        bus0.enc_b = 1'b0;
        repeat (10) @(negedge clk);
        bus0.btn_up = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("up plus enc_dec cancel", int'(bus0.sel), 2);
        applyStimulus(4'b1100, 10);
        checkOutput("up plus down cancel", int'(bus0.sel), 2);

        // Select change mid half-period: level holds, next toggle two cycles later
        expQ.push_back(4'd1);
        @(negedge clk);
        bus0.btn_down = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus0.sel != 4'd1 && n < 30);
        checkOutput("down reaches sel=1", int'(bus0.sel), 1);
        d0 = bus0.clk_div;
        checkOutput("level held on sel change", int'(d0), int'(prevDiv));
        @(negedge clk);
        checkOutput("no toggle 1 cycle after change", int'(bus0.clk_div), int'(d0));
        @(negedge clk);
        checkOutput("toggle 2 cycles after change", int'(bus0.clk_div), int'(!d0));
        checkOutput("tick with toggle", int'(bus0.clk_tick), 1);
        repeat (8) @(negedge clk);
        bus0.btn_down = 1'b0;
        repeat (12) @(negedge clk);
        waitDrain("down press");

        // Reset during a press: SEL returns to its initial value and the press is lost
        expQ.push_back(4'd3);
        @(negedge clk);
        bus0.btn_up = 1'b1;
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset mid-press clk_div", int'(bus0.clk_div), 0);
        bus0.btn_up = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        repeat (20) @(negedge clk);
        waitDrain("reset mid-press");
        checkOutput("sel after reset mid-press", int'(bus0.sel), 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
